hyperbus_io_ctrl: RTL
=====================

Name: hyperbus_io_ctrl

Overview:
Parametrised pad-side sequencer between the HyperBus PHY and the IO pad ring. It generalises the fixed 8-bit, 2-chip pad wrapper in three ways: DQ width, chip-select count and turnaround timing are parameters. It adds sequential control the fixed wrapper lacks: a registered output stage, a bus-turnaround guard FSM against drive contention, a device reset-pulse generator and a one-hot chip-select checker. Pad cells are instantiated outside this block and connect to its pad_* ports.

Parameters:
DqWidth, 8, DQ lanes (8 or 16 only).
NumChips, 2, chip-select outputs (1..8).
TurnCycles, 2, oe-low guard cycles after TX before bus release (>=1).
RstPulseCycles, 16, cycles pad_reset_no is held low (>=1).
RstRecovCycles, 32, cycles after reset release before ready (>=1).

Ports:
clk_i  in  1  single clock, sole clock domain of the block.
rst_i  in  1  asynchronous, active-high reset.
phy_dq_i  in  DqWidth  data to drive.
phy_dq_oe_i  in  1  PHY requests drive of DQ/RWDS.
phy_rwds_i  in  1  RWDS value to drive.
phy_cs_ni  in  NumChips  active-low chip selects from PHY.
phy_ck_en_i  in  1  enables the device clock.
phy_tx_ready_o  out  1  drive request accepted (state TX).
phy_dq_o  out  DqWidth  registered sampled DQ.
phy_rwds_o  out  1  registered sampled RWDS.
phy_rx_valid_o  out  1  phy_dq_o/phy_rwds_o valid.
hw_rst_req_i  in  1  pulse: issue a device reset.
cs_err_clr_i  in  1  clears cs_err_o.
rst_busy_o  out  1  reset sequence in progress.
cs_err_o  out  1  sticky: multiple chip selects requested.
pad_dq_o / pad_dq_i  out/in  DqWidth  pad data.
pad_dq_oe_o  out  1  DQ output enable.
pad_rwds_o / pad_rwds_i  out/in  1  pad RWDS.
pad_rwds_oe_o  out  1  RWDS output enable.
pad_cs_no  out  NumChips  chip selects to pads.
pad_ck_o / pad_ck_no  out  1  differential device clock.
pad_reset_no  out  1  device reset, active low.

Behaviour:
- Reset values: pad_dq_o=0, pad_*_oe_o=0, pad_cs_no=all 1, pad_ck_o=0, pad_ck_no=1, pad_reset_no=0, rst_busy_o=1, phy_tx_ready_o=0, phy_rx_valid_o=0, phy_dq_o=0, phy_rwds_o=0, cs_err_o=0.
- All pad outputs are registered: 1-cycle latency from phy_* inputs.
- Reset generator FSM RST_LOW -> RST_WAIT -> READY:
  - RST_LOW: entered when rst_i is released; pad_reset_no=0 for exactly RstPulseCycles.
  - RST_WAIT: pad_reset_no=1 for RstRecovCycles.
  - READY: rst_busy_o=0.
  - hw_rst_req_i in READY restarts at RST_LOW on the next cycle. hw_rst_req_i while busy is ignored.
- While rst_busy_o=1: pad_cs_no all 1, oe=0, clock held, direction FSM forced to HIZ.
- Direction FSM HIZ / TX / GUARD:
  - HIZ: oe=0. phy_dq_oe_i=1 -> TX.
  - TX: pad_dq_oe_o=pad_rwds_oe_o=1 and phy_tx_ready_o=1; both asserted the cycle after entry. phy_dq_oe_i=0 -> GUARD.
  - GUARD: oe=0 for TurnCycles, then HIZ. phy_dq_oe_i=1 during GUARD is held off (tx_ready=0) until HIZ, then TX.
- RX: pad_dq_i and pad_rwds_i are registered every cycle. phy_rx_valid_o=1 the cycle after a sample taken in HIZ with some pad_cs_no low. phy_rx_valid_o=0 for samples taken in TX or GUARD.
- Chip select:
  - Zero or one bit of phy_cs_ni low: passed to pad_cs_no with 1-cycle latency.
  - Two or more low: pad_cs_no all 1, and cs_err_o is set next cycle.
  - cs_err_o clears only via cs_err_clr_i or rst_i. A simultaneous set and clear resolves to set.
- Clock: pad_ck_o toggles every cycle (clk_i/2) while phy_ck_en_i=1 and some CS is asserted; otherwise it returns to 0 on the next cycle. pad_ck_no is always the inverse of pad_ck_o.
- Counters are $clog2(max+1) bits and saturate at terminal count; no wrap.
- rst_i mid-sequence: all state returns to reset values immediately (async); RST_LOW restarts on release.

Decomposition:
- Package hyperbus_io_pkg:
  - dir_state_e (HIZ/TX/GUARD) and rst_state_e (RST_LOW/RST_WAIT/READY).
  - Default timing constants.
  - Function onehot0_check.
- Sub-module hyperbus_rst_gen: reset FSM plus counter; outputs pad_reset_no and rst_busy_o.

Test Plan:
- Power-on: release rst_i, defaults -> pad_reset_no low exactly 16 cycles, then high; rst_busy_o falls after 32 further cycles.
- TX then RX: phy_dq_oe_i=1, phy_dq_i=8'hA5 -> next cycle pad_dq_o=A5, pad_dq_oe_o=1. Drop oe -> oe low with rx_valid=0 for 2 cycles, then rx_valid follows pad_dq_i=8'h3C one cycle late.
- Re-request during GUARD: phy_dq_oe_i re-asserted 1 cycle into GUARD -> phy_tx_ready_o stays 0 until HIZ, then TX; pad_dq_oe_o is never 1 in GUARD.
- CS error: phy_cs_ni=2'b00 -> pad_cs_no=2'b11 and cs_err_o=1. With cs_err_clr_i and set pulsed together, cs_err_o stays 1. cs_err_clr_i alone clears it.
- hw_rst_req_i in READY during an active CS -> CS released and oe=0; 16-cycle low pulse follows. A second request while busy is ignored.
- DqWidth=16, NumChips=4: one-hot CS walk and 16'hBEEF TX/RX round trip pass unchanged.

Source files
------------

// File: rtl/hyperbus_io_pkg.sv
// Shared types, default timing and helpers for the HyperBus pad-side sequencer.
package hyperbus_io_pkg;

  typedef enum logic [1:0] {
    HIZ   = 2'd0,
    TX    = 2'd1,
    GUARD = 2'd2
  } dir_state_e;

  typedef enum logic [1:0] {
    RST_LOW  = 2'd0,
    RST_WAIT = 2'd1,
    READY    = 2'd2
  } rst_state_e;

  localparam int unsigned DefDqWidth        = 8;
  localparam int unsigned DefNumChips       = 2;
  localparam int unsigned DefTurnCycles     = 2;
  localparam int unsigned DefRstPulseCycles = 16;
  localparam int unsigned DefRstRecovCycles = 32;
  localparam int unsigned MaxChips          = 8;

  // True when zero or one bit of sel is set.
  function automatic logic onehot0_check(input logic [MaxChips-1:0] sel);
    return (sel & (sel - MaxChips'(1))) == '0;
  endfunction

endpackage

// File: rtl/hyperbus_rst_gen.sv
// Device reset-pulse generator: low pulse, recovery wait, then ready.
module hyperbus_rst_gen
  import hyperbus_io_pkg::*;
#(
  parameter int unsigned RstPulseCycles = DefRstPulseCycles,
  parameter int unsigned RstRecovCycles = DefRstRecovCycles
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic hw_rst_req_i,
  output logic pad_reset_no,
  output logic rst_busy_o,
  output logic busy_next_c
);

  localparam int unsigned CntMax = (RstPulseCycles > RstRecovCycles) ? RstPulseCycles
                                                                     : RstRecovCycles;
  localparam int unsigned CntW = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] PulseLast = CntW'(RstPulseCycles - 1);
  localparam logic [CntW-1:0] RecovLast = CntW'(RstRecovCycles - 1);
  localparam logic [CntW-1:0] CntTop    = CntW'(CntMax);

  rst_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= RST_LOW;
      cnt_q        <= '0;
      pad_reset_no <= 1'b0;
      rst_busy_o   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pad_reset_no <= (state_d != RST_LOW);
      rst_busy_o   <= busy_next_c;
    end
  end

  // Each state counts its own dwell; the counter restarts on every transition.
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == CntTop) ? cnt_q : cnt_q + CntW'(1);
    busy_next_c = 1'b1;
    unique case (state_q)
      RST_LOW: begin
        if (cnt_q == PulseLast) begin
          state_d = RST_WAIT;
          cnt_d   = '0;
        end
      end
      RST_WAIT: begin
        if (cnt_q == RecovLast) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY: begin
        if (hw_rst_req_i) begin
          state_d = RST_LOW;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RST_LOW;
        cnt_d   = '0;
      end
    endcase
    busy_next_c = (state_d != READY);
  end

endmodule

// File: rtl/hyperbus_io_ctrl.sv
// Pad-side HyperBus sequencer: registered pad stage, turnaround guard,
// device reset sequencing and chip-select sanity checking.
module hyperbus_io_ctrl
  import hyperbus_io_pkg::*;
#(
  parameter int unsigned DqWidth        = DefDqWidth,
  parameter int unsigned NumChips       = DefNumChips,
  parameter int unsigned TurnCycles     = DefTurnCycles,
  parameter int unsigned RstPulseCycles = DefRstPulseCycles,
  parameter int unsigned RstRecovCycles = DefRstRecovCycles
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DqWidth-1:0]  phy_dq_i,
  input  logic                phy_dq_oe_i,
  input  logic                phy_rwds_i,
  input  logic [NumChips-1:0] phy_cs_ni,
  input  logic                phy_ck_en_i,
  output logic                phy_tx_ready_o,
  output logic [DqWidth-1:0]  phy_dq_o,
  output logic                phy_rwds_o,
  output logic                phy_rx_valid_o,
  input  logic                hw_rst_req_i,
  input  logic                cs_err_clr_i,
  output logic                rst_busy_o,
  output logic                cs_err_o,
  output logic [DqWidth-1:0]  pad_dq_o,
  input  logic [DqWidth-1:0]  pad_dq_i,
  output logic                pad_dq_oe_o,
  output logic                pad_rwds_o,
  input  logic                pad_rwds_i,
  output logic                pad_rwds_oe_o,
  output logic [NumChips-1:0] pad_cs_no,
  output logic                pad_ck_o,
  output logic                pad_ck_no,
  output logic                pad_reset_no
);

  localparam int unsigned TurnW = $clog2(TurnCycles + 1);
  localparam logic [TurnW-1:0] TurnLast = TurnW'(TurnCycles - 1);

  dir_state_e          dir_q, dir_d;
  logic [TurnW-1:0]    turn_q, turn_d;
  logic                busy_c;
  logic                cs_multi_c;
  logic                cs_active_c;
  logic                ck_run_c;
  logic [NumChips-1:0] cs_req_c;

  hyperbus_rst_gen #(
    .RstPulseCycles(RstPulseCycles),
    .RstRecovCycles(RstRecovCycles)
  ) u_rst_gen (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .hw_rst_req_i(hw_rst_req_i),
    .pad_reset_no(pad_reset_no),
    .rst_busy_o  (rst_busy_o),
    .busy_next_c (busy_c)
  );

  // busy_c is the reset generator's next-cycle view, so pads release on the same edge.
  assign cs_req_c    = ~phy_cs_ni;
  assign cs_multi_c  = !onehot0_check(MaxChips'(cs_req_c));
  assign cs_active_c = !busy_c && !cs_multi_c && (|cs_req_c);
  assign ck_run_c    = phy_ck_en_i && cs_active_c;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dir_q  <= HIZ;
      turn_q <= '0;
    end else begin
      dir_q  <= dir_d;
      turn_q <= turn_d;
    end
  end

  // Direction FSM: a GUARD gap always separates TX from the next bus release.
  always_comb begin
    dir_d  = dir_q;
    turn_d = turn_q;
    unique case (dir_q)
      HIZ: begin
        if (phy_dq_oe_i) dir_d = TX;
      end
      TX: begin
        if (!phy_dq_oe_i) begin
          dir_d  = GUARD;
          turn_d = '0;
        end
      end
      GUARD: begin
        if (turn_q == TurnLast) dir_d = HIZ;
        else                    turn_d = turn_q + TurnW'(1);
      end
      default: dir_d = HIZ;
    endcase
    if (busy_c) begin
      dir_d  = HIZ;
      turn_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pad_dq_o       <= '0;
      pad_rwds_o     <= 1'b0;
      pad_dq_oe_o    <= 1'b0;
      pad_rwds_oe_o  <= 1'b0;
      phy_tx_ready_o <= 1'b0;
      pad_cs_no      <= '1;
      pad_ck_o       <= 1'b0;
      pad_ck_no      <= 1'b1;
      phy_dq_o       <= '0;
      phy_rwds_o     <= 1'b0;
      phy_rx_valid_o <= 1'b0;
      cs_err_o       <= 1'b0;
    end else begin
      pad_dq_o       <= phy_dq_i;
      pad_rwds_o     <= phy_rwds_i;
      pad_dq_oe_o    <= (dir_d == TX);
      pad_rwds_oe_o  <= (dir_d == TX);
      phy_tx_ready_o <= (dir_d == TX);
      pad_cs_no      <= (busy_c || cs_multi_c) ? '1 : phy_cs_ni;
      pad_ck_o       <= ck_run_c ? ~pad_ck_o : 1'b0;
      pad_ck_no      <= ck_run_c ? pad_ck_o : 1'b1;
      phy_dq_o       <= pad_dq_i;
      phy_rwds_o     <= pad_rwds_i;
      // Only samples taken with the bus released and a device selected are data.
      phy_rx_valid_o <= (dir_q == HIZ) && !(&pad_cs_no);
      cs_err_o       <= cs_multi_c ? 1'b1 : (cs_err_clr_i ? 1'b0 : cs_err_o);
    end
  end

endmodule
